// File: rtl/ef_i2s_tx.sv
// ef_i2s_tx -- I2S master transmitter (Philips format, MSB first).
//
// Audio words are buffered in an internal FIFO. The core divides the system
// clock down to a serial bit clock and emits 64-slot frames: left channel in
// slots 0..31 (ws=0), right channel in slots 32..63 (ws=1). The sample MSB
// sits one slot after each ws edge.
//
// Ports:
//   clk_i            system clock, rising edge
//   rst_i            synchronous active-high reset
//   en_i             transmitter enable
//   prescaler_i      sck half-period minus one, in clk cycles
//   sample_size_i    bits per channel sample (1..32, 0 means 32)
//   mono_i           one FIFO word per frame, sent on both channels
//   wr_i, wdata_i    FIFO write strobe and right-aligned sample
//   clr_underflow_i  clears the sticky underflow flag
//   full_o, empty_o  FIFO status (registered)
//   level_o          FIFO occupancy 0..2^AW (registered)
//   underflow_o      sticky: a pop hit an empty FIFO
//   sck_o, ws_o      serial bit clock and word select
//   sdo_o            serial data, stable around each rising sck
module ef_i2s_tx #(
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic [7:0]    prescaler_i,
  input  logic [5:0]    sample_size_i,
  input  logic          mono_i,
  input  logic          wr_i,
  input  logic [31:0]   wdata_i,
  input  logic          clr_underflow_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o,
  output logic          underflow_o,
  output logic          sck_o,
  output logic          ws_o,
  output logic          sdo_o
);

  localparam int            Depth     = 1 << AW;
  localparam logic [AW:0]   FullLevel = (AW+1)'(Depth);
  localparam logic [AW:0]   LevelOne  = (AW+1)'(1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  // FIFO storage and bookkeeping
  logic [31:0]   mem_q [Depth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          underflow_q, underflow_d;

  // Serial engine state
  logic [7:0]  cnt_q;
  logic        sck_q;
  logic        ws_q;
  logic        sdo_q;
  logic [5:0]  p_q;
  logic [31:0] shreg_q;
  logic [31:0] hold_q;

  // Combinational helpers
  logic        tick;
  logic        fallTick;
  logic [5:0]  pNext;
  logic        leftLoad;
  logic        rightLoad;
  logic        popReq;
  logic        popOk;
  logic        wrOk;
  logic [31:0] popWord;
  logic [31:0] loadWord;
  logic [5:0]  ssEff;
  logic [5:0]  alignShift;
  logic [31:0] aligned;

  // A tick toggles sck; ws, sdo and the slot counter only move on the
  // falling-sck ticks so they stay stable across the receiver's rising edge.
  // Loading happens when entering slot 1 (left) or 33 (right).
  always_comb begin
    tick      = en_i && (cnt_q == prescaler_i);
    fallTick  = tick && sck_q;
    pNext     = p_q + 6'd1;
    leftLoad  = fallTick && (pNext == 6'd1);
    rightLoad = fallTick && (pNext == 6'd33);
    popReq    = leftLoad || (rightLoad && !mono_i);
    popOk     = popReq && !empty_q;
    wrOk      = wr_i && !full_q;
  end

  // The word to send is left-justified into the shift register so the
  // sample MSB lands in bit 31; zeros shift in behind it, which naturally
  // fills the unused slots with 0. Sizes above 32 are clamped to 32.
  always_comb begin
    popWord    = empty_q ? 32'd0 : mem_q[rptr_q];
    loadWord   = (rightLoad && mono_i) ? hold_q : popWord;
    ssEff      = ((sample_size_i == 6'd0) || (sample_size_i > 6'd32)) ? 6'd32 : sample_size_i;
    alignShift = 6'd32 - ssEff;
    aligned    = loadWord << alignShift;
  end

  // Occupancy next state; a write uses the pre-pop full flag, so a write
  // and pop together on a full FIFO drops the write and lowers the level.
  always_comb begin
    level_d = level_q;
    case ({wrOk, popOk})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == FullLevel);
    empty_d = (level_d == '0);
  end

  // Underflow is sticky; a set in the same cycle as a clear wins.
  always_comb begin
    underflow_d = underflow_q;
    if (popReq && empty_q) begin
      underflow_d = 1'b1;
    end else if (clr_underflow_i) begin
      underflow_d = 1'b0;
    end
  end

  // FIFO data array, no reset needed: pointers define validity.
  always_ff @(posedge clk_i) begin
    if (wrOk) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // FIFO pointers and registered status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      if (wrOk) begin
        wptr_q <= wptr_q + PtrOne;
      end
      if (popOk) begin
        rptr_q <= rptr_q + PtrOne;
      end
      level_q     <= level_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      underflow_q <= underflow_d;
    end
  end

  // Clock divider, frame slot counter and serialiser. Disabling parks every
  // serial output low and restarts the frame, dropping any partly sent word.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q   <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b0;
      sdo_q   <= 1'b0;
      p_q     <= '0;
      shreg_q <= '0;
      hold_q  <= '0;
    end else begin
      if (tick) begin
        cnt_q <= '0;
        sck_q <= ~sck_q;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (fallTick) begin
        p_q  <= pNext;
        ws_q <= pNext[5];
        if (leftLoad || rightLoad) begin
          sdo_q   <= aligned[31];
          shreg_q <= aligned << 1;
        end else begin
          sdo_q   <= shreg_q[31];
          shreg_q <= shreg_q << 1;
        end
        if (leftLoad) begin
          hold_q <= popWord;
        end
      end
    end
  end

  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign level_o     = level_q;
  assign underflow_o = underflow_q;
  assign sck_o       = sck_q;
  assign ws_o        = ws_q;
  assign sdo_o       = sdo_q;

endmodule

// File: tb/tb_ef_i2s_tx.sv
// tb_ef_i2s_tx -- self-checking bench for ef_i2s_tx.
//
// A behavioural model keeps the accepted FIFO words in a queue and, as each
// sck rising edge is observed, predicts the slot contents of the frame from
// the I2S slot rules (MSB at slot 1 / 33, sample_size bits, zeros elsewhere).
// Drives and samples both happen on the falling clk edge from one thread.
module tb_ef_i2s_tx;

  localparam int AW    = 4;
  localparam int Depth = 16;
  localparam int MaxSlots = 1100;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [7:0]    prescaler;
  logic [5:0]    sampleSize;
  logic          mono;
  logic          wr;
  logic [31:0]   wdata;
  logic          clrUnderflow;
  logic          fullO;
  logic          emptyO;
  logic [AW:0]   levelO;
  logic          underflowO;
  logic          sckO;
  logic          wsO;
  logic          sdoO;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] modelQ [$];
  bit          modelUnder;
  int          curP;
  int          curSs;
  bit          curMono;

  bit gotSdo [MaxSlots];
  bit gotWs  [MaxSlots];
  bit expSdo [MaxSlots];

  always #5 clk = ~clk;

  ef_i2s_tx #(.AW(AW)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .prescaler_i     (prescaler),
    .sample_size_i   (sampleSize),
    .mono_i          (mono),
    .wr_i            (wr),
    .wdata_i         (wdata),
    .clr_underflow_i (clrUnderflow),
    .full_o          (fullO),
    .empty_o         (emptyO),
    .level_o         (levelO),
    .underflow_o     (underflowO),
    .sck_o           (sckO),
    .ws_o            (wsO),
    .sdo_o           (sdoO)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic setConfig(input int p, input int ss, input bit m);
    prescaler  = 8'(p);
    sampleSize = 6'(ss);
    mono       = m;
    curP       = p;
    curSs      = (ss == 0) ? 32 : ss;
    curMono    = m;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; wr = 1'b0; clrUnderflow = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelQ.delete();
    modelUnder = 1'b0;
  endtask

  task automatic writeWord(input logic [31:0] w);
    wr = 1'b1;
    wdata = w;
    @(negedge clk);
    wr = 1'b0;
    if (modelQ.size() < Depth) modelQ.push_back(w);
  endtask

  // Enables the core, captures nSlots sck rising edges, predicts every slot
  // from the model, optionally pulses clr_underflow after slot clrSlot,
  // then disables the core and compares.
  task automatic applyStimulus(input int nSlots, input int clrSlot, input string name);
    int k = 0;
    int sinceRise = 0;
    int periodErr = 0;
    int violations = 0;
    bit timedOut = 1'b0;
    bit clrPending = 1'b0;
    logic prevSck, prevWs, prevSdo;
    logic [31:0] word;
    logic [31:0] monoWord = 32'd0;
    logic [31:0] gotW, expW, gotWsW, expWsW;
    for (int i = 0; i < MaxSlots; i++) expSdo[i] = 1'b0;
    prevSck = sckO; prevWs = wsO; prevSdo = sdoO;
    en = 1'b1;
    while (k < nSlots && !timedOut) begin
      @(negedge clk);
      sinceRise++;
      if ((wsO !== prevWs || sdoO !== prevSdo) && !(prevSck === 1'b1 && sckO === 1'b0))
        violations++;
      if (clrPending) begin
        checkOutput($sformatf("%s_underflow_cleared", name), underflowO, 0);
        clrUnderflow = 1'b0;
        modelUnder = 1'b0;
        clrPending = 1'b0;
      end
      if (prevSck === 1'b0 && sckO === 1'b1) begin
        if (k == 0) checkOutput($sformatf("%s_first_rise", name), sinceRise, curP + 1);
        else if (sinceRise != 2 * (curP + 1)) periodErr++;
        gotSdo[k] = sdoO;
        gotWs[k]  = wsO;
        if (k % 64 == 1 || k % 64 == 33) begin
          if (k % 64 == 33 && curMono) begin
            word = monoWord;
          end else if (modelQ.size() > 0) begin
            word = modelQ.pop_front();
          end else begin
            word = 32'd0;
            modelUnder = 1'b1;
          end
          if (k % 64 == 1) monoWord = word;
          for (int j = 1; j <= curSs; j++) expSdo[k + j - 1] = word[curSs - j];
          checkOutput($sformatf("%s_level_slot%0d", name, k), levelO, modelQ.size());
          checkOutput($sformatf("%s_underflow_slot%0d", name, k), underflowO, modelUnder);
        end
        if (k == clrSlot) begin
          clrUnderflow = 1'b1;
          clrPending = 1'b1;
        end
        sinceRise = 0;
        k++;
      end
      prevSck = sckO; prevWs = wsO; prevSdo = sdoO;
      if (sinceRise > 2 * (curP + 1) + 4) begin
        checkOutput($sformatf("%s_sck_timeout", name), 1, 0);
        timedOut = 1'b1;
      end
    end
    en = 1'b0;
    clrUnderflow = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("%s_disable_sck_ws_sdo", name), {sckO, wsO, sdoO}, 0);
    checkOutput($sformatf("%s_period_errors", name), periodErr, 0);
    checkOutput($sformatf("%s_ws_sdo_stability", name), violations, 0);
    for (int c = 0; c * 32 < k; c++) begin
      gotW = '0; expW = '0; gotWsW = '0; expWsW = '0;
      for (int b = 0; b < 32; b++) begin
        if (c * 32 + b < k) begin
          gotW[b]   = gotSdo[c * 32 + b];
          expW[b]   = expSdo[c * 32 + b];
          gotWsW[b] = gotWs[c * 32 + b];
          expWsW[b] = ((c * 32 + b) % 64) >= 32;
        end
      end
      checkOutput($sformatf("%s_sdo_slots%0d", name, c * 32), gotW, expW);
      checkOutput($sformatf("%s_ws_slots%0d", name, c * 32), gotWsW, expWsW);
    end
    checkOutput($sformatf("%s_end_level", name), levelO, modelQ.size());
    checkOutput($sformatf("%s_end_empty", name), emptyO, modelQ.size() == 0);
    checkOutput($sformatf("%s_end_full", name), fullO, modelQ.size() == Depth);
    checkOutput($sformatf("%s_end_underflow", name), underflowO, modelUnder);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr = 1'b0; wdata = '0; clrUnderflow = 1'b0;
    setConfig(0, 16, 1'b0);
    modelUnder = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_serial", {sckO, wsO, sdoO}, 0);
    checkOutput("reset_status", {fullO, emptyO, underflowO}, 3'b010);
    checkOutput("reset_level", levelO, 0);
    rst = 1'b0;

    // Stereo, 16-bit samples, fastest sck
    doReset();
    setConfig(0, 16, 1'b0);
    writeWord(32'h0000A5A5);
    writeWord(32'h00003C3C);
    checkOutput("stereo_level_before", levelO, 2);
    applyStimulus(65, -1, "stereo");

    // Empty FIFO: silent output, sticky underflow and its clear
    doReset();
    setConfig(0, 16, 1'b0);
    applyStimulus(40, 12, "underflow");

    // Mono: one pop per frame, word repeated on the right channel
    doReset();
    setConfig(0, 8, 1'b1);
    writeWord(32'h000000F0);
    writeWord(32'h00000055);
    applyStimulus(65, -1, "mono");

    // Fill to full, drop the overflow write, then drain in order
    doReset();
    setConfig(0, 32, 1'b0);
    for (int i = 0; i < 17; i++) begin
      writeWord($urandom);
      if (i == 15) begin
        checkOutput("full_after16", fullO, 1);
        checkOutput("level_after16", levelO, 16);
      end
    end
    checkOutput("full_after17", fullO, 1);
    checkOutput("level_after17", levelO, 16);
    applyStimulus(513, -1, "full");

    // Disable mid-frame at slot 20, then resume with the next word
    doReset();
    setConfig(0, 16, 1'b0);
    for (int i = 0; i < 3; i++) writeWord($urandom);
    applyStimulus(21, -1, "disable_a");
    applyStimulus(40, -1, "disable_b");

    // Slow sck and full 32-bit samples
    doReset();
    setConfig(3, 32, 1'b0);
    writeWord(32'h80000001);
    writeWord(32'h80000001);
    applyStimulus(65, -1, "presc");
    checkOutput("presc_msb_p1", gotSdo[1], 1);
    checkOutput("presc_lsb_p32", gotSdo[32], 1);
    checkOutput("presc_ws_p32", gotWs[32], 1);

    // Randomized configurations and contents
    for (int it = 0; it < 4; it++) begin
      doReset();
      setConfig($urandom_range(0, 3), $urandom_range(0, 32), 1'($urandom_range(0, 1)));
      for (int i = 0; i < $urandom_range(1, 5); i++) writeWord($urandom);
      applyStimulus(64 * $urandom_range(1, 2) + 1, -1, $sformatf("rand%0d", it));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
